// File: rtl/sweep_controller.sv
// rtl/sweep_controller.sv - two-axis scan-and-lock sweep sequencer
module sweep_controller #(
    parameter int POS_W        = 8,
    parameter int LIGHT_W      = 12,
    parameter int DWELL_W      = 13,
    parameter int DWELL_CYCLES = 8191,
    parameter int H_MAX        = 180,
    parameter int V_MAX        = 90
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               START,
    input  logic               ABORT,
    input  logic [LIGHT_W-1:0] LIGHT,
    input  logic               LIGHT_VLD,
    output logic               HS,
    output logic               VS,
    output logic [POS_W-1:0]   H_POS,
    output logic [POS_W-1:0]   V_POS,
    output logic [POS_W-1:0]   H_BEST,
    output logic [POS_W-1:0]   V_BEST,
    output logic               BUSY,
    output logic               DONE
);
    typedef enum logic [2:0] {IDLE, H_SWEEP, H_GOTO, V_SWEEP, V_GOTO} state_t;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
    localparam logic [POS_W-1:0]   H_LAST     = POS_W'(H_MAX);
    localparam logic [POS_W-1:0]   V_LAST     = POS_W'(V_MAX);
    localparam logic [POS_W-1:0]   POS_ONE    = POS_W'(1);

    state_t             state, state_n;
    logic [DWELL_W-1:0] dwell, dwell_n;
    logic [LIGHT_W-1:0] sample, sample_n, best, best_n;
    logic               sample_vld, sample_vld_n;
    logic [POS_W-1:0]   h_pos_n, v_pos_n, h_best_n, v_best_n;
    logic               done_n, dwell_end, better;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            dwell      <= '0;
            sample     <= '0;
            best       <= '0;
            sample_vld <= 1'b0;
            H_POS      <= '0;
            V_POS      <= '0;
            H_BEST     <= '0;
            V_BEST     <= '0;
            HS         <= 1'b0;
            VS         <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            state      <= state_n;
            dwell      <= dwell_n;
            sample     <= sample_n;
            best       <= best_n;
            sample_vld <= sample_vld_n;
            H_POS      <= h_pos_n;
            V_POS      <= v_pos_n;
            H_BEST     <= h_best_n;
            V_BEST     <= v_best_n;
            HS         <= (state_n == H_SWEEP) || (state_n == H_GOTO);
            VS         <= (state_n == V_SWEEP) || (state_n == V_GOTO);
            BUSY       <= (state_n != IDLE);
            DONE       <= done_n;
        end
    end

    always_comb begin
        state_n      = state;
        dwell_n      = dwell;
        sample_n     = sample;
        best_n       = best;
        sample_vld_n = sample_vld;
        h_pos_n      = H_POS;
        v_pos_n      = V_POS;
        h_best_n     = H_BEST;
        v_best_n     = V_BEST;
        done_n       = 1'b0;
        dwell_end    = (dwell == DWELL_LAST);
        better       = sample_vld && (sample > best);

        case (state)
            IDLE: begin
                if (START && !ABORT) begin
                    state_n      = H_SWEEP;
                    h_pos_n      = '0;
                    h_best_n     = '0;
                    best_n       = '0;
                    dwell_n      = '0;
                    sample_vld_n = 1'b0;
                end
            end
            H_SWEEP, V_SWEEP: begin
                if (!dwell_end) begin
                    dwell_n = dwell + DWELL_ONE;
                    if (LIGHT_VLD) begin
                        sample_n     = LIGHT;
                        sample_vld_n = 1'b1;
                    end
                end else begin
                    dwell_n      = '0;
                    sample_vld_n = 1'b0;
                    if (better) best_n = sample;
                    if (state == H_SWEEP) begin
                        if (better) h_best_n = H_POS;
                        // Park uses the just-updated best so the final position can win.
                        if (H_POS == H_LAST) begin
                            state_n = H_GOTO;
                            h_pos_n = h_best_n;
                        end else begin
                            h_pos_n = H_POS + POS_ONE;
                        end
                    end else begin
                        if (better) v_best_n = V_POS;
                        if (V_POS == V_LAST) begin
                            state_n = V_GOTO;
                            v_pos_n = v_best_n;
                        end else begin
                            v_pos_n = V_POS + POS_ONE;
                        end
                    end
                end
            end
            H_GOTO: begin
                if (dwell_end) begin
                    dwell_n      = '0;
                    state_n      = V_SWEEP;
                    v_pos_n      = '0;
                    v_best_n     = '0;
                    best_n       = '0;
                    sample_vld_n = 1'b0;
                end else begin
                    dwell_n = dwell + DWELL_ONE;
                end
            end
            V_GOTO: begin
                if (dwell_end) begin
                    dwell_n = '0;
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    dwell_n = dwell + DWELL_ONE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Abort freezes positions and best results; only sequencing state is dropped.
        if (state != IDLE && ABORT) begin
            state_n      = IDLE;
            dwell_n      = '0;
            sample_vld_n = 1'b0;
            sample_n     = sample;
            best_n       = best;
            h_pos_n      = H_POS;
            v_pos_n      = V_POS;
            h_best_n     = H_BEST;
            v_best_n     = V_BEST;
            done_n       = 1'b0;
        end
    end
endmodule

// File: tb/tb_sweep_controller.sv
// tb/tb_sweep_controller.sv - scoreboard bench for sweep_controller
module tb_sweep_controller;
    localparam int D  = 4;
    localparam int HM = 3;
    localparam int VM = 2;

    logic       CLK = 1'b0;
    logic       RST_N, START, ABORT, LIGHT_VLD;
    logic [11:0] LIGHT;
    logic       HS, VS, BUSY, DONE;
    logic [7:0] H_POS, V_POS, H_BEST, V_BEST;

    sweep_controller #(
        .POS_W(8), .LIGHT_W(12), .DWELL_W(13),
        .DWELL_CYCLES(D), .H_MAX(HM), .V_MAX(VM)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT),
        .LIGHT(LIGHT), .LIGHT_VLD(LIGHT_VLD),
        .HS(HS), .VS(VS), .H_POS(H_POS), .V_POS(V_POS),
        .H_BEST(H_BEST), .V_BEST(V_BEST), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int hv[4], hd[4], vv[3], vd[3];

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_pop(input string tag, input int got);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s got=%0d exp=<queue empty>", tag, got);
        end else begin
            check(tag, got, exp_q.pop_front());
        end
    endtask

    // abort_k / busy_start_k: cycle after the START edge in which to assert; 0 = never
    task automatic run(input int abort_k, input int busy_start_k);
        int hb, hbv, vb, vbv;
        int hs_cnt, vs_cnt, hs_first, vs_first, done_cnt, done_cyc;
        int hgoto, vgoto, overlap, ab_hs, ab_vs, ab_busy;
        hb = 0; hbv = 0; vb = 0; vbv = 0;
        for (int p = 0; p <= HM; p++)
            if (hd[p] >= 0 && hd[p] <= D - 2 && hv[p] > hbv) begin hbv = hv[p]; hb = p; end
        for (int p = 0; p <= VM; p++)
            if (vd[p] >= 0 && vd[p] <= D - 2 && vv[p] > vbv &&
                (abort_k == 0 || 24 + 4 * p < abort_k)) begin vbv = vv[p]; vb = p; end
        if (abort_k == 0) begin
            exp_q.push_back((HM + 2) * D);
            exp_q.push_back((VM + 2) * D);
            exp_q.push_back(1);
            exp_q.push_back((HM + 2) * D + 1);
            exp_q.push_back(1);
            exp_q.push_back(37);
            exp_q.push_back(hb);
            exp_q.push_back(vb);
        end else begin
            exp_q.push_back((HM + 2) * D);
            exp_q.push_back(abort_k - (HM + 2) * D);
            exp_q.push_back(0);
            exp_q.push_back(0);
            exp_q.push_back(0);
            exp_q.push_back(0);
            exp_q.push_back(hb);
            exp_q.push_back((abort_k - 21) / D);
        end
        exp_q.push_back(hb);
        exp_q.push_back(vb);

        hs_cnt = 0; vs_cnt = 0; hs_first = 0; vs_first = 0; done_cnt = 0; done_cyc = 0;
        hgoto = -1; vgoto = -1; overlap = 0; ab_hs = 0; ab_vs = 0; ab_busy = 0;
        START = 1'b1;
        @(posedge CLK); #1;
        for (int k = 1; k <= 44; k++) begin
            LIGHT_VLD = 1'b0;
            LIGHT     = '0;
            if (k <= 16 && hd[(k - 1) / D] == (k - 1) % D) begin
                LIGHT_VLD = 1'b1;
                LIGHT     = 12'(hv[(k - 1) / D]);
            end
            if (k >= 21 && k <= 32 && vd[(k - 21) / D] == (k - 21) % D) begin
                LIGHT_VLD = 1'b1;
                LIGHT     = 12'(vv[(k - 21) / D]);
            end
            ABORT = (k == abort_k);
            START = (k == busy_start_k);
            @(negedge CLK);
            if (HS) begin hs_cnt++; if (hs_first == 0) hs_first = k; end
            if (VS) begin vs_cnt++; if (vs_first == 0) vs_first = k; end
            if (HS && VS) overlap++;
            if (DONE) begin done_cnt++; done_cyc = k; end
            if (k == 18) hgoto = int'(H_POS);
            if (k == 34) vgoto = int'(V_POS);
            if (abort_k != 0 && k == abort_k + 1) begin
                ab_hs = int'(HS); ab_vs = int'(VS); ab_busy = int'(BUSY);
                hgoto = int'(H_POS); vgoto = int'(V_POS);
            end
            @(posedge CLK); #1;
        end
        ABORT = 1'b0;
        START = 1'b0;
        LIGHT_VLD = 1'b0;
        if (abort_k == 0) begin
            check_pop("hs_len", hs_cnt);
            check_pop("vs_len", vs_cnt);
            check_pop("hs_first", hs_first);
            check_pop("vs_first", vs_first);
            check_pop("done_cnt", done_cnt);
            check_pop("done_cyc", done_cyc);
        end else begin
            check_pop("hs_len", hs_cnt);
            check_pop("vs_len", vs_cnt);
            check_pop("done_cnt", done_cnt);
            check_pop("abort_hs", ab_hs);
            check_pop("abort_vs", ab_vs);
            check_pop("abort_busy", ab_busy);
        end
        check_pop("h_park", hgoto);
        check_pop("v_park", vgoto);
        check_pop("h_best", int'(H_BEST));
        check_pop("v_best", int'(V_BEST));
        check("hs_vs_overlap", overlap, 0);
    endtask

    task automatic set_peak();
        hv = '{10, 50, 90, 20}; hd = '{1, 1, 1, 1};
        vv = '{5, 70, 30};      vd = '{1, 1, 1};
    endtask

    initial begin
        RST_N = 1'b0; START = 1'b0; ABORT = 1'b0; LIGHT_VLD = 1'b0; LIGHT = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_hs", int'(HS), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_done", int'(DONE), 0);
        check("rst_hbest", int'(H_BEST), 0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(posedge CLK); #1;

        set_peak();
        run(0, 10);

        hv = '{10, 60, 20, 60};
        run(0, 0);

        hd = '{-1, -1, -1, -1}; vd = '{-1, -1, -1};
        run(0, 0);

        hv = '{10, 10, 10, 200}; hd = '{1, 1, 1, 3};
        vv = '{5, 70, 30};       vd = '{1, 1, 1};
        run(0, 0);

        set_peak();
        run(26, 0);

        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        check("midrst_hs", int'(HS), 0);
        check("midrst_busy", int'(BUSY), 0);
        check("midrst_hpos", int'(H_POS), 0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(posedge CLK); #1;
        set_peak();
        run(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sweep_controller.md
# sweep_controller

Scan-and-lock sequencer for the two-axis light tracker. On START it runs the horizontal axis through every position from 0 to H_MAX. At each position it dwells a fixed number of cycles and records the position with the brightest light sample, then parks the axis there. It repeats the same procedure on the vertical axis. It drives the HS and VS sweep enables consumed by the axis counters and servo drivers, and reports the locked position.

## Interface
- POS_W, 8: width of position outputs.
- LIGHT_W, 12: width of the light sample.
- DWELL_W, 13: width of the dwell counter.
- DWELL_CYCLES, 8191: cycles spent at each position; must be at least 2 and must fit in DWELL_W.
- H_MAX, 180: last horizontal position; must fit in POS_W.
- V_MAX, 90: last vertical position; must fit in POS_W.
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  level; sampled only in IDLE.
- ABORT  in  1  level; returns to IDLE from any busy state.
- LIGHT  in  LIGHT_W  unsigned light sample.
- LIGHT_VLD  in  1  LIGHT is valid this cycle.
- HS  out  1  horizontal sweep enable.
- VS  out  1  vertical sweep enable.
- H_POS  out  POS_W  commanded horizontal position.
- V_POS  out  POS_W  commanded vertical position.
- H_BEST  out  POS_W  brightest horizontal position found.
- V_BEST  out  POS_W  brightest vertical position found.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  one-cycle pulse on completion.

## Operation
- Reset values: state IDLE; all outputs 0; dwell counter 0; sample register and best value 0; sample-valid flag 0.
- States: IDLE, H_SWEEP, H_GOTO, V_SWEEP, V_GOTO.
- IDLE:
  - With START=1 and ABORT=0: go to H_SWEEP, set H_POS=0, H_BEST=0, best value 0, dwell counter 0, sample flag 0.
- H_SWEEP (HS=1):
  - Dwell counter runs 0 to DWELL_CYCLES-1.
  - In dwell cycles 0 to DWELL_CYCLES-2, each LIGHT_VLD=1 loads LIGHT into the sample register and sets the sample flag. A later valid sample overwrites an earlier one.
  - A sample in the last dwell cycle is discarded.
  - Last dwell cycle: if the flag is set and sample > best (strict), best takes the sample and H_BEST takes H_POS. Ties keep the earlier position.
  - Then the flag clears and the dwell counter goes to 0.
  - If H_POS==H_MAX, go to H_GOTO with H_POS set to H_BEST. Otherwise H_POS increments.
- H_GOTO (HS=1):
  - Holds H_POS for DWELL_CYCLES cycles to settle.
  - Then goes to V_SWEEP with V_POS=0, V_BEST=0, best value 0, flag 0.
- V_SWEEP (VS=1): identical rules to H_SWEEP on V_POS, V_BEST and V_MAX. At the end goes to V_GOTO with V_POS set to V_BEST.
- V_GOTO (VS=1):
  - Holds V_POS for DWELL_CYCLES cycles.
  - Then goes to IDLE with DONE=1 for exactly that first IDLE cycle.
- No valid sample during a whole sweep: the BEST output stays 0 and the axis parks at 0.
- ABORT=1 in any busy state: next cycle is IDLE with HS=VS=0. H_POS, V_POS, H_BEST and V_BEST keep their values. No DONE pulse.
- ABORT has priority over START. START while BUSY is ignored.
- START held high through DONE: the next sweep starts in the cycle after DONE; DONE and the restart are not both registered in the same cycle.
- HS and VS are never high together.
- Positions never exceed H_MAX or V_MAX; no wrap-around.

## Timing
- All outputs are registered.
- START sampled at edge N gives HS=1, BUSY=1, H_POS=0 from cycle N+1.
- Each position lasts exactly DWELL_CYCLES cycles. H_POS changes on the edge that ends the last dwell cycle.
- HS high for (H_MAX+2)·DWELL_CYCLES consecutive cycles.
- VS rises in the cycle after HS falls and stays high for (V_MAX+2)·DWELL_CYCLES cycles.
- DONE and BUSY=0 occur in the cycle after VS falls.
- BEST outputs update on the edge that ends the last dwell cycle of the winning position.
- RST_N low at any time, including mid-sweep, clears everything immediately. Operation resumes at the first edge after RST_N rises, with START then required again.

## Test plan
Bench parameters: DWELL_CYCLES=4, H_MAX=3, V_MAX=2.

- Peak sweep: LIGHT_VLD pulsed once per position in dwell cycle 1, with horizontal values 10,50,90,20 and vertical values 5,70,30.
  - H_BEST=2; H_POS=2 during H_GOTO.
  - V_BEST=1; V_POS=1 during V_GOTO.
  - HS high for 20 cycles, then VS high for 16.
  - DONE pulses once, 37 cycles after the START edge.
- Tie: equal values 60 at horizontal positions 1 and 3 → H_BEST=1.
- No LIGHT_VLD at all → H_BEST=V_BEST=0 and DONE still arrives at cycle 37.
- Late sample: value 200 at position 3 presented only in dwell cycle 3, other positions at 10 → sample discarded, H_BEST=0.
- Control:
  - ABORT in V_SWEEP cycle 5 → IDLE the next cycle, HS=VS=0, no DONE, positions held.
  - START pulsed while BUSY → no effect.
- Reset: RST_N low for 1 cycle in the middle of H_SWEEP → all outputs 0 immediately. A fresh START then gives the full 37-cycle sequence.
